// File: rtl/mcu_spi_if.sv
// Target-side bus of the MCU SPI front end: byte strobes, payload and replies.
// master is the SPI deframer, slave is a target block such as sysctrl.
interface mcu_spi_if;
   logic       mcu_start;
   logic [7:0] mcu_dout;
   logic       mcu_sys_strobe;
   logic       mcu_hid_strobe;
   logic       mcu_osd_strobe;
   logic       mcu_sdc_strobe;
   logic [7:0] mcu_sys_din;
   logic [7:0] mcu_hid_din;
   logic [7:0] mcu_osd_din;
   logic [7:0] mcu_sdc_din;

   modport master (
      output mcu_start, mcu_dout,
      output mcu_sys_strobe, mcu_hid_strobe,
      output mcu_osd_strobe, mcu_sdc_strobe,
      input  mcu_sys_din, mcu_hid_din,
      input  mcu_osd_din, mcu_sdc_din
   );

   modport slave (
      input  mcu_start, mcu_dout,
      input  mcu_sys_strobe, mcu_hid_strobe,
      input  mcu_osd_strobe, mcu_sdc_strobe,
      output mcu_sys_din, mcu_hid_din,
      output mcu_osd_din, mcu_sdc_din
   );
endinterface

// File: rtl/mcu_spi.sv
// SPI slave front end: syncs MCU pins into clk, deframes bytes, routes
// each frame to a target by its first byte and returns replies on MISO.
module mcu_spi #(
   parameter logic [7:0] TGT_SYS = 8'd1,
   parameter logic [7:0] TGT_HID = 8'd2,
   parameter logic [7:0] TGT_OSD = 8'd3,
   parameter logic [7:0] TGT_SDC = 8'd4
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      spi_csn,
   input  logic      spi_sclk,
   input  logic      spi_mosi,
   output logic      spi_miso,
   mcu_spi_if.master mcu
);

   typedef enum logic [1:0] {IDLE, TARGET, CMD, DATA} state_t;
   typedef enum logic [2:0] {T_NONE, T_SYS, T_HID, T_OSD, T_SDC} tgt_t;

   state_t     state;
   tgt_t       tgt;
   tgt_t       id_tgt;
   logic [2:0] csn_s;
   logic [2:0] sclk_s;
   logic [1:0] mosi_s;
   logic [6:0] rx;
   logic [7:0] tx;
   logic [7:0] dout;
   logic [2:0] bitcnt;
   logic [3:0] stb;
   logic [3:0] sel;
   logic [7:0] rep;
   logic [7:0] byte_in;
   logic       start;
   logic       ld_p;
   logic       ld_d;
   logic       ldz_p;
   logic       ldz_d;
   logic       csn_q;
   logic       csn_fall;
   logic       sclk_rise;
   logic       sclk_fall;

   assign csn_q     = csn_s[1];
   assign csn_fall  = csn_s[2] & ~csn_s[1];
   assign sclk_rise = ~sclk_s[2] & sclk_s[1];
   assign sclk_fall = sclk_s[2] & ~sclk_s[1];
   assign byte_in   = {rx, mosi_s[1]};

   always_comb begin
      id_tgt = T_NONE;
      unique case (1'b1)
         (byte_in == TGT_SYS): id_tgt = T_SYS;
         (byte_in == TGT_HID): id_tgt = T_HID;
         (byte_in == TGT_OSD): id_tgt = T_OSD;
         (byte_in == TGT_SDC): id_tgt = T_SDC;
         default:              id_tgt = T_NONE;
      endcase
   end

   always_comb begin
      sel = 4'b0000;
      rep = 8'h00;
      case (tgt)
         T_SYS: begin sel = 4'b0001; rep = mcu.mcu_sys_din; end
         T_HID: begin sel = 4'b0010; rep = mcu.mcu_hid_din; end
         T_OSD: begin sel = 4'b0100; rep = mcu.mcu_osd_din; end
         T_SDC: begin sel = 4'b1000; rep = mcu.mcu_sdc_din; end
         default: ;
      endcase
   end

   // csn sync resets low so a reset taken with csn held low
   // does not fake a frame start; the frame resumes only on a real fall.
   always_ff @(posedge clk) begin
      if (reset) begin
         csn_s  <= 3'b000;
         sclk_s <= 3'b000;
         mosi_s <= 2'b00;
         state  <= IDLE;
         tgt    <= T_NONE;
         rx     <= 7'h00;
         tx     <= 8'h00;
         dout   <= 8'h00;
         bitcnt <= 3'd0;
         stb    <= 4'b0000;
         start  <= 1'b0;
         ld_p   <= 1'b0;
         ld_d   <= 1'b0;
         ldz_p  <= 1'b0;
         ldz_d  <= 1'b0;
      end else begin
         csn_s  <= {csn_s[1:0], spi_csn};
         sclk_s <= {sclk_s[1:0], spi_sclk};
         mosi_s <= {mosi_s[0], spi_mosi};
         stb    <= 4'b0000;
         start  <= 1'b0;
         ld_p   <= 1'b0;
         ld_d   <= ld_p;
         ldz_d  <= ldz_p;
         if (csn_fall) begin
            state  <= TARGET;
            tgt    <= T_NONE;
            bitcnt <= 3'd0;
            tx     <= 8'h00;
            ld_d   <= 1'b0;
         end else if (csn_q) begin
            state  <= IDLE;
            bitcnt <= 3'd0;
         end else if (state != IDLE) begin
            // The fall closing a byte (bitcnt back at 0) keeps the
            // reply MSB in place for the next byte's first rise.
            if (ld_d)
               tx <= ldz_d ? 8'h00 : rep;
            else if (sclk_fall && bitcnt != 3'd0)
               tx <= {tx[6:0], 1'b0};
            if (sclk_rise) begin
               rx     <= byte_in[6:0];
               bitcnt <= bitcnt + 3'd1;
               if (bitcnt == 3'd7) begin
                  ld_p <= 1'b1;
                  unique case (state)
                     TARGET: begin
                        tgt   <= id_tgt;
                        state <= CMD;
                        ldz_p <= 1'b1;
                     end
                     CMD: begin
                        dout  <= byte_in;
                        state <= DATA;
                        ldz_p <= 1'b0;
                        stb   <= sel;
                        start <= (tgt != T_NONE);
                     end
                     DATA: begin
                        dout  <= byte_in;
                        ldz_p <= 1'b0;
                        stb   <= sel;
                     end
                     default: ;
                  endcase
               end
            end
         end
      end
   end

   assign spi_miso           = tx[7];
   assign mcu.mcu_start      = start;
   assign mcu.mcu_dout       = dout;
   assign mcu.mcu_sys_strobe = stb[0];
   assign mcu.mcu_hid_strobe = stb[1];
   assign mcu.mcu_osd_strobe = stb[2];
   assign mcu.mcu_sdc_strobe = stb[3];

endmodule

// File: tb/tb_mcu_spi.sv
// Directed bench for mcu_spi: drives MCU-side SPI frames at clk/8 and
// checks target strobes, payload, start flag and MISO replies.
module tb_mcu_spi;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic csn = 1'b1;
   logic sclk = 1'b0;
   logic mosi = 1'b0;
   logic miso;

   mcu_spi_if bus();

   mcu_spi dut (
      .clk      (clk),
      .reset    (reset),
      .spi_csn  (csn),
      .spi_sclk (sclk),
      .spi_mosi (mosi),
      .spi_miso (miso),
      .mcu      (bus)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int multi = 0;
   int longs = 0;
   int orphan = 0;
   int ev_tgt[$];
   logic ev_start[$];
   logic [7:0] ev_dout[$];
   logic [3:0] prev = 4'b0000;
   logic [3:0] s;

   always @(negedge clk) begin
      s = {bus.mcu_sdc_strobe, bus.mcu_osd_strobe,
           bus.mcu_hid_strobe, bus.mcu_sys_strobe};
      if ($countones(s) > 1) multi++;
      if ((s & prev) != 4'b0000) longs++;
      if (bus.mcu_start && s == 4'b0000) orphan++;
      if (s != 4'b0000) begin
         case (s)
            4'b0001: ev_tgt.push_back(0);
            4'b0010: ev_tgt.push_back(1);
            4'b0100: ev_tgt.push_back(2);
            default: ev_tgt.push_back(3);
         endcase
         ev_start.push_back(bus.mcu_start);
         ev_dout.push_back(bus.mcu_dout);
      end
      prev = s;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic spi_bits(input logic [7:0] b, input int n,
                           output logic [7:0] r);
      r = 8'h00;
      for (int i = 7; i > 7 - n; i--) begin
         mosi = b[i];
         #40;
         r[i] = miso;
         sclk = 1'b1;
         #40;
         sclk = 1'b0;
      end
   endtask

   task automatic frame_begin();
      ev_tgt.delete();
      ev_start.delete();
      ev_dout.delete();
      csn = 1'b0;
      #80;
   endtask

   task automatic frame_end();
      #40;
      csn = 1'b1;
      #200;
   endtask

   logic [7:0] r;
   logic [7:0] rb[5];
   logic [7:0] rt_id[3];
   logic [7:0] rt_pl[3];
   logic [7:0] acc;

   initial begin
      rt_id = '{8'h02, 8'h03, 8'h04};
      rt_pl = '{8'hA5, 8'h3C, 8'hFF};
      bus.mcu_sys_din = 8'h00;
      bus.mcu_hid_din = 8'h00;
      bus.mcu_osd_din = 8'h00;
      bus.mcu_sdc_din = 8'h00;
      #32;
      check_eq("rst_dout", bus.mcu_dout, 8'h00);
      check_eq("rst_start", bus.mcu_start, 1'b0);
      check_eq("rst_stb", {bus.mcu_sdc_strobe, bus.mcu_osd_strobe,
               bus.mcu_hid_strobe, bus.mcu_sys_strobe}, 4'h0);
      check_eq("rst_miso", miso, 1'b0);
      reset = 1'b0;
      #40;

      // basic sys frame with reply 5C
      bus.mcu_sys_din = 8'h5C;
      frame_begin();
      spi_bits(8'h01, 8, rb[0]);
      for (int i = 1; i < 5; i++) spi_bits(8'h00, 8, rb[i]);
      frame_end();
      check_eq("sys_cnt", ev_tgt.size(), 4);
      if (ev_tgt.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            check_eq("sys_tgt", ev_tgt[i], 0);
            check_eq("sys_start", ev_start[i], (i == 0));
            check_eq("sys_dout", ev_dout[i], 8'h00);
         end
      end
      check_eq("sys_miso1", rb[1], 8'h00);
      for (int i = 2; i < 5; i++) check_eq("sys_miso", rb[i], 8'h5C);

      // routing to hid / osd / sdc
      for (int k = 0; k < 3; k++) begin
         frame_begin();
         spi_bits(rt_id[k], 8, r);
         spi_bits(rt_pl[k], 8, r);
         frame_end();
         check_eq("rt_cnt", ev_tgt.size(), 1);
         if (ev_tgt.size() == 1) begin
            check_eq("rt_tgt", ev_tgt[0], k + 1);
            check_eq("rt_start", ev_start[0], 1'b1);
            check_eq("rt_dout", ev_dout[0], rt_pl[k]);
         end
      end

      // unknown target: nothing fires, MISO stays 0
      bus.mcu_sys_din = 8'hC3;
      bus.mcu_hid_din = 8'h81;
      bus.mcu_osd_din = 8'hFF;
      bus.mcu_sdc_din = 8'h7E;
      orphan = 0;
      frame_begin();
      spi_bits(8'h07, 8, rb[0]);
      spi_bits(8'h11, 8, rb[1]);
      spi_bits(8'h22, 8, rb[2]);
      frame_end();
      acc = rb[0] | rb[1] | rb[2];
      check_eq("unk_cnt", ev_tgt.size(), 0);
      check_eq("unk_start", orphan, 0);
      check_eq("unk_miso", acc, 8'h00);

      // aborted frame, partial byte dropped
      frame_begin();
      spi_bits(8'h01, 8, r);
      spi_bits(8'h04, 8, r);
      spi_bits(8'h53, 8, r);
      spi_bits(8'hFF, 5, r);
      frame_end();
      check_eq("abt_cnt", ev_tgt.size(), 2);
      if (ev_tgt.size() == 2) begin
         check_eq("abt_dout0", ev_dout[0], 8'h04);
         check_eq("abt_start0", ev_start[0], 1'b1);
         check_eq("abt_dout1", ev_dout[1], 8'h53);
         check_eq("abt_start1", ev_start[1], 1'b0);
      end
      frame_begin();
      spi_bits(8'h01, 8, r);
      spi_bits(8'h05, 8, r);
      frame_end();
      check_eq("rst_cnt", ev_tgt.size(), 1);
      if (ev_tgt.size() == 1) begin
         check_eq("rst_start1", ev_start[0], 1'b1);
         check_eq("rst_dout1", ev_dout[0], 8'h05);
      end

      // reset in the middle of a frame
      frame_begin();
      spi_bits(8'h01, 8, r);
      spi_bits(8'h04, 8, r);
      #20;
      reset = 1'b1;
      #30;
      reset = 1'b0;
      spi_bits(8'h41, 8, r);
      spi_bits(8'h01, 8, r);
      #80;
      check_eq("mid_dout", bus.mcu_dout, 8'h00);
      check_eq("mid_start", bus.mcu_start, 1'b0);
      check_eq("mid_miso", miso, 1'b0);
      frame_end();
      check_eq("mid_cnt", ev_tgt.size(), 1);

      // reply path: C3 shifted out on the byte after the command
      bus.mcu_sys_din = 8'hC3;
      frame_begin();
      spi_bits(8'h01, 8, rb[0]);
      spi_bits(8'h10, 8, rb[1]);
      spi_bits(8'h77, 8, rb[2]);
      frame_end();
      check_eq("rep_cnt", ev_tgt.size(), 2);
      check_eq("rep_cmd", rb[1], 8'h00);
      check_eq("rep_byte", rb[2], 8'hC3);

      check_eq("onehot", multi, 0);
      check_eq("one_cycle", longs, 0);
      check_eq("orphan", orphan, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
